// File: rtl/l1_cache_lookup.sv
// Direct-mapped, one-word-per-line L1 lookup and single-word refill stage.
// Each lookup is answered combinationally while the FSM is idle. A miss
// latches the request and refills the line from the next memory level over a
// req/ready handshake. The FSM then returns the refilled word to the core
// with a one-cycle fill_valid pulse.
module l1_cache_lookup #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic        flush,
  output logic        hit,
  output logic        miss,
  output logic [31:0] hit_data,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        fill_valid,
  output logic [31:0] fill_data
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  mem_req_q, mem_req_d;
  logic                  fill_valid_q, fill_valid_d;
  logic [31:0]           fill_data_q, fill_data_d;
  // Word address of the outstanding miss; byte offset is never needed.
  logic [29:0]           req_addr_q, req_addr_d;

  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [31:0]           data_q [LINES];

  logic [INDEX_BITS-1:0] cpu_idx, req_idx;
  logic [TAG_BITS-1:0]   cpu_tag, req_tag;
  logic                  is_idle, line_match, fill_we;
  logic                  unused_addr_bits;

  assign cpu_idx    = cpu_addr[INDEX_BITS+1:2];
  assign cpu_tag    = cpu_addr[31:INDEX_BITS+2];
  assign req_idx    = req_addr_q[INDEX_BITS-1:0];
  assign req_tag    = req_addr_q[29:INDEX_BITS];
  // Byte offset within the word has no meaning for a word-granular cache.
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign is_idle    = (state_q == IDLE);
  assign line_match = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);

  // Lookup outputs; flush wins over any lookup in the same cycle.
  assign hit        = is_idle & cpu_req & ~flush & line_match;
  assign miss       = is_idle & cpu_req & ~flush & ~line_match;
  assign hit_data   = data_q[cpu_idx];
  // DONE releases the core: the refilled word is handed over that cycle.
  assign stall      = (state_q == REQ) | (is_idle & (miss | flush));

  assign mem_req    = mem_req_q;
  assign mem_addr   = {req_addr_q, 2'b00};
  assign fill_valid = fill_valid_q;
  assign fill_data  = fill_data_q;

  // Next-state, valid-bit and handshake logic for the refill FSM.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    mem_req_d    = mem_req_q;
    fill_valid_d = 1'b0;
    fill_data_d  = fill_data_q;
    req_addr_d   = req_addr_q;
    fill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (miss) begin
          req_addr_d = cpu_addr[31:2];
          mem_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        // A flush cannot drop the in-flight refill; remember it for DONE.
        if (flush) flush_pend_d = 1'b1;
        if (mem_ready) begin
          fill_we          = 1'b1;
          valid_d[req_idx] = 1'b1;
          fill_valid_d     = 1'b1;
          fill_data_d      = mem_data;
          mem_req_d        = 1'b0;
          state_d          = DONE;
        end
      end
      DONE: begin
        // The returned word is still delivered; only the array is invalidated.
        if (flush_pend_q | flush) valid_d = '0;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // FSM state, valid bits and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_data_q  <= '0;
      req_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      mem_req_q    <= mem_req_d;
      fill_valid_q <= fill_valid_d;
      fill_data_q  <= fill_data_d;
      req_addr_q   <= req_addr_d;
    end
  end

  // Tag/data arrays are unreset; valid_q alone decides whether a line is live.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem_data;
    end
  end

endmodule

// File: tb/tb_l1_cache_lookup.sv
// Scenario bench for l1_cache_lookup: refill words are queued when memory
// returns them and popped when the DUT pulses fill_valid.
module tb_l1_cache_lookup;
  logic        clk = 1'b0;
  logic        reset, cpu_req, flush, mem_ready;
  logic [31:0] cpu_addr, mem_data;
  logic        hit, miss, stall, mem_req, fill_valid;
  logic [31:0] hit_data, mem_addr, fill_data;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_d;

  l1_cache_lookup #(.INDEX_BITS(6)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .flush(flush), .hit(hit), .miss(miss), .hit_data(hit_data),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .fill_valid(fill_valid),
    .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Memory side: wait `delay` cycles, then return d and queue it as expected.
  task automatic refill(input logic [31:0] d, input int delay);
    for (int i = 0; i < delay; i++) begin mem_ready = 1'b0; tick(); end
    mem_ready = 1'b1; mem_data = d; sb.push_back(d);
    tick();
    mem_ready = 1'b0; mem_data = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_ready = 1'b0; mem_data = '0;
    tick(); tick();
    reset = 1'b0; #1;
    total++; if ({hit, miss, stall, mem_req, fill_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=00000", {hit, miss, stall, mem_req, fill_valid}); end
  endtask

  task automatic test_miss_fill;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0104; #1;
    total++; if ({hit, miss, stall} !== 3'b011) begin
      bad++; $display("FAIL first_miss hit/miss/stall got=%b exp=011", {hit, miss, stall}); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0104 || stall !== 1'b1) begin
      bad++; $display("FAIL req_phase mem_req=%b mem_addr=%h stall=%b exp 1/00000104/1", mem_req, mem_addr, stall); end
    refill(32'hDEAD_BEEF, 0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d || stall !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL fill_deadbeef fv=%b data=%h stall=%b mem_req=%b exp 1/%h/0/0", fill_valid, fill_data, stall, mem_req, exp_d); end
    tick(); #1;
    total++; if (hit !== 1'b1 || hit_data !== 32'hDEAD_BEEF || stall !== 1'b0) begin
      bad++; $display("FAIL rehit_104 hit=%b data=%h stall=%b exp 1/deadbeef/0", hit, hit_data, stall); end
    cpu_req = 1'b0;
  endtask

  task automatic test_conflict;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0204; #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL conflict_miss_204 hit/miss got=%b exp=01", {hit, miss}); end
    tick();
    refill(32'h1111_1111, 0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d) begin
      bad++; $display("FAIL fill_1111 fv=%b data=%h exp 1/%h", fill_valid, fill_data, exp_d); end
    tick(); #1;
    total++; if (hit !== 1'b1 || hit_data !== 32'h1111_1111) begin
      bad++; $display("FAIL hit_204 hit=%b data=%h exp 1/11111111", hit, hit_data); end
    cpu_addr = 32'h0000_0104; #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL evicted_104 hit/miss got=%b exp=01", {hit, miss}); end
    cpu_req = 1'b0;
  endtask

  task automatic test_stall_wait;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0300; #1;
    total++; if (miss !== 1'b1) begin
      bad++; $display("FAIL miss_300 got=%b exp=1", miss); end
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0300 || stall !== 1'b1 || fill_valid !== 1'b0) begin
        bad++; $display("FAIL wait_cycle%0d mem_req=%b addr=%h stall=%b fv=%b exp 1/00000300/1/0", i, mem_req, mem_addr, stall, fill_valid); end
      tick();
    end
    refill(32'hCAFE_0300, 0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d) begin
      bad++; $display("FAIL fill_after_wait fv=%b data=%h exp 1/%h", fill_valid, fill_data, exp_d); end
    cpu_req = 1'b0;
  endtask

  task automatic test_flush_req;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0400; #1;
    total++; if (miss !== 1'b1) begin
      bad++; $display("FAIL miss_400 got=%b exp=1", miss); end
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    refill(32'h4444_0400, 1);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d) begin
      bad++; $display("FAIL fill_during_flush fv=%b data=%h exp 1/%h", fill_valid, fill_data, exp_d); end
    tick(); #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL flushed_400 hit/miss got=%b exp=01", {hit, miss}); end
    cpu_addr = 32'h0000_0204; #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL flushed_204 hit/miss got=%b exp=01", {hit, miss}); end
    cpu_req = 1'b0;
  endtask

  task automatic test_flush_idle;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0104;
    tick();
    refill(32'hA5A5_0104, 0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d) begin
      bad++; $display("FAIL fill_a5a5 fv=%b data=%h exp 1/%h", fill_valid, fill_data, exp_d); end
    tick(); #1;
    total++; if (hit !== 1'b1 || hit_data !== 32'hA5A5_0104) begin
      bad++; $display("FAIL hit_a5a5 hit=%b data=%h exp 1/a5a50104", hit, hit_data); end
    flush = 1'b1; #1;
    total++; if ({hit, miss, stall} !== 3'b001) begin
      bad++; $display("FAIL idle_flush hit/miss/stall got=%b exp=001", {hit, miss, stall}); end
    tick(); flush = 1'b0; cpu_req = 1'b0; #1;
    cpu_req = 1'b1; #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL after_idle_flush hit/miss got=%b exp=01", {hit, miss}); end
    cpu_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0108;
    tick();
    refill(32'hB2B0_0108, 0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d) begin
      bad++; $display("FAIL b2b_fill0 fv=%b data=%h exp 1/%h", fill_valid, fill_data, exp_d); end
    cpu_addr = 32'h0000_010C; #1;
    total++; if ({miss, stall} !== 2'b00) begin
      bad++; $display("FAIL b2b_done_quiet miss/stall got=%b exp=00", {miss, stall}); end
    tick(); #1;
    total++; if ({miss, stall} !== 2'b11) begin
      bad++; $display("FAIL b2b_next_miss miss/stall got=%b exp=11", {miss, stall}); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_010C) begin
      bad++; $display("FAIL b2b_req mem_req=%b addr=%h exp 1/0000010c", mem_req, mem_addr); end
    refill(32'hB2B1_010C, 0);
    exp_d = (sb.size() != 0) ? sb.pop_front() : 32'hx;
    total++; if (fill_valid !== 1'b1 || fill_data !== exp_d) begin
      bad++; $display("FAIL b2b_fill1 fv=%b data=%h exp 1/%h", fill_valid, fill_data, exp_d); end
    cpu_req = 1'b0;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0108; #1;
    total++; if (hit !== 1'b1 || hit_data !== 32'hB2B0_0108) begin
      bad++; $display("FAIL b2b_hit108 hit=%b data=%h exp 1/b2b00108", hit, hit_data); end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    tick(); cpu_req = 1'b1; cpu_addr = 32'h0000_0500;
    tick();
    total++; if (mem_req !== 1'b1) begin
      bad++; $display("FAIL req_500 mem_req=%b exp=1", mem_req); end
    reset = 1'b1; cpu_req = 1'b0;
    tick(); reset = 1'b0;
    total++; if ({mem_req, stall, fill_valid} !== 3'b000) begin
      bad++; $display("FAIL post_reset mem_req/stall/fv got=%b exp=000", {mem_req, stall, fill_valid}); end
    mem_ready = 1'b1; mem_data = 32'h5555_0500;
    tick(); mem_ready = 1'b0;
    total++; if ({mem_req, fill_valid} !== 2'b00) begin
      bad++; $display("FAIL late_ready mem_req/fv got=%b exp=00", {mem_req, fill_valid}); end
    cpu_req = 1'b1; cpu_addr = 32'h0000_0108; #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL reset_lost_108 hit/miss got=%b exp=01", {hit, miss}); end
    cpu_addr = 32'h0000_0500; #1;
    total++; if ({hit, miss} !== 2'b01) begin
      bad++; $display("FAIL late_ready_500 hit/miss got=%b exp=01", {hit, miss}); end
    cpu_req = 1'b0;
    tick();
    total++; if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_conflict();
    test_stall_wait();
    test_flush_req();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
